// File: rtl/maze_pkg.sv
// Shared maze definitions: direction codes, default coordinate width and
// the walker state encoding.
package maze_pkg;

    localparam int COORD_W_DEF = 4;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WALK  = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } walk_state_e;

endpackage

// File: rtl/dir_step.sv
// One maze step: next (x,y) for a direction code, plus a flag when the move
// would leave the maze. On out-of-bounds the position is returned unchanged.
module dir_step
    import maze_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         code,
    output logic [COORD_W-1:0] nx,
    output logic [COORD_W-1:0] ny,
    output logic               oob
);

    localparam logic [COORD_W-1:0] MAX_C = '1;
    localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);

    // Bounds-checked step, unsigned coordinates.
    always_comb begin
        nx  = x;
        ny  = y;
        oob = 1'b0;
        case (code)
            DIR_UP: begin
                if (y == '0) oob = 1'b1;
                else         ny  = y - ONE_C;
            end
            DIR_DOWN: begin
                if (y == MAX_C) oob = 1'b1;
                else            ny  = y + ONE_C;
            end
            DIR_LEFT: begin
                if (x == '0) oob = 1'b1;
                else         nx  = x - ONE_C;
            end
            DIR_RIGHT: begin
                if (x == MAX_C) oob = 1'b1;
                else            nx  = x + ONE_C;
            end
            default: begin
                oob = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/path_walker.sv
// Consumes the path-queue direction stream, walks (x,y) from the start cell,
// flags attempts to leave the maze and reports whether the goal was reached.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | after reset, waiting for start
//   ST_WALK  | applying accepted direction codes until stream_done
//   ST_CHECK | one cycle: compare final position against goal
//   ST_DONE  | result held until the next start
module path_walker
    import maze_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int COORD_W = COORD_W_DEF,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 15,
    parameter int GOAL_Y  = 15,
    parameter int CNT_W   = 9,
    parameter bit INVERT  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir_valid,
    input  logic [WIDTH-1:0]   dir_in,
    input  logic               stream_done,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               pos_valid,
    output logic [CNT_W-1:0]   step_count,
    output logic               busy,
    output logic               done,
    output logic               reached_goal,
    output logic               err_bounds
);

    localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] GOAL_XC  = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] GOAL_YC  = COORD_W'(GOAL_Y);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    walk_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               goal_q, goal_d;
    logic               pos_valid_q, pos_valid_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   code;
    logic [COORD_W-1:0] step_x, step_y;
    logic               step_oob;

    // Reversed paths are walked by flipping every code bit (up<->down, left<->right).
    assign code = INVERT ? ~dir_in : dir_in;

    dir_step #(.COORD_W(COORD_W)) u_dir_step (
        .x    (x_q),
        .y    (y_q),
        .code (code[1:0]),
        .nx   (step_x),
        .ny   (step_y),
        .oob  (step_oob)
    );

    // Next-state and register updates for the walk FSM.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        goal_d      = goal_q;
        pos_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    x_d     = START_XC;
                    y_d     = START_YC;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    goal_d  = 1'b0;
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                if (dir_valid) begin
                    // An illegal move is still counted; only the position holds.
                    if (step_oob) begin
                        err_d = 1'b1;
                    end else begin
                        x_d = step_x;
                        y_d = step_y;
                    end
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    pos_valid_d = 1'b1;
                end
                if (stream_done) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                goal_d  = (x_q == GOAL_XC) && (y_q == GOAL_YC) && !err_q;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            x_q         <= START_XC;
            y_q         <= START_YC;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            goal_q      <= 1'b0;
            pos_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            goal_q      <= goal_d;
            pos_valid_q <= pos_valid_d;
            done_q      <= done_d;
        end
    end

    assign x_out        = x_q;
    assign y_out        = y_q;
    assign step_count   = cnt_q;
    assign err_bounds   = err_q;
    assign reached_goal = goal_q;
    assign pos_valid    = pos_valid_q;
    assign done         = done_q;
    assign busy         = (state_q == ST_WALK) || (state_q == ST_CHECK);

endmodule

// File: doc/path_walker.md
Name: path_walker

Overview:
- Consumer end of the maze direction stream produced by the path queue.
- Accepts 2-bit direction codes one per cycle, walks an (x,y) position from a start cell, and checks each move against maze bounds.
- On end-of-stream, reports whether the walk ended on the goal cell.
- Sits between the path queue output and the top-level result/display logic of the maze solver.

Parameters:
- WIDTH, 2, direction code width. Codes: 00 up, 01 right, 10 left, 11 down.
- COORD_W, 4, coordinate width. The maze is 2^COORD_W x 2^COORD_W.
- START_X, 0, start column.
- START_Y, 0, start row.
- GOAL_X, 15, goal column.
- GOAL_Y, 15, goal row.
- CNT_W, 9, step counter width.
- INVERT, 0, when 1 each code is bitwise-inverted before use (up<->down, left<->right), for walking a reversed path.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a new walk; sampled in IDLE or DONE.
- dir_valid  input  1  dir_in valid this cycle.
- dir_in  input  WIDTH  direction code.
- stream_done  input  1  end-of-stream pulse from the queue (read_finished).
- x_out  output  COORD_W  current column.
- y_out  output  COORD_W  current row.
- pos_valid  output  1  one-cycle pulse: x_out/y_out updated by an accepted move.
- step_count  output  CNT_W  accepted moves this walk.
- busy  output  1  high in WALK and CHECK.
- done  output  1  one-cycle pulse on entering DONE.
- reached_goal  output  1  final position equals goal; valid in DONE.
- err_bounds  output  1  sticky: a move attempted to leave the maze.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; x_out=START_X, y_out=START_Y; all other outputs 0. Reset mid-walk discards everything.
- States: IDLE, WALK, CHECK, DONE.
- IDLE/DONE + start=1:
  - Load x=START_X, y=START_Y.
  - Clear step_count, err_bounds, reached_goal.
  - Go to WALK next cycle.
  - reached_goal holds its value in DONE until start.
- WALK + dir_valid=1: apply code c = INVERT ? ~dir_in : dir_in.
  - up: y-1. down: y+1. left: x-1. right: x+1.
  - Coordinates are unsigned.
  - If the move would underflow 0 or exceed 2^COORD_W-1: position holds, err_bounds sets (sticky until next start), the step is still counted.
  - step_count increments and saturates at 2^CNT_W-1.
  - pos_valid=1 in the cycle after acceptance, with the new x_out/y_out.
  - Latency: 1 cycle from dir_valid to updated outputs.
- WALK + stream_done=1: go to CHECK.
  - If dir_valid is also high that cycle, that direction is applied first.
  - stream_done with no moves is legal: step_count=0 and the position stays at start.
- CHECK, one cycle: reached_goal = (x==GOAL_X && y==GOAL_Y && !err_bounds). Go to DONE; done pulses on that transition.
- DONE: outputs hold; dir_valid and stream_done are ignored.
- start is ignored in WALK/CHECK.
- dir_valid is ignored in IDLE, CHECK and DONE.
- stream_done is ignored outside WALK.
- pos_valid and done are never high together.

Decomposition:
- Shared package maze_pkg:
  - Direction constants DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10, DIR_DOWN=2'b11.
  - Default COORD_W.
  - State encoding for IDLE/WALK/CHECK/DONE.
- One combinational sub-module dir_step:
  - Inputs: x, y, code.
  - Outputs: next x, next y, out_of_bounds.
  - Reused by the queue-side golden model in the bench.
- The FSM, counter and registers stay in path_walker.

Test Plan:
1. Reset, start, then stream right,right,down,down (01,01,11,11), then stream_done. Expect x/y sequence (1,0),(2,0),(2,1),(2,2); step_count=4; four pos_valid pulses; done pulse; reached_goal=0; err_bounds=0.
2. Start, then 15×right + 15×down, then stream_done. Expect (15,15), step_count=30, reached_goal=1.
3. From start, send up (00). Expect position stays (0,0), err_bounds=1, step_count=1. After stream_done, reached_goal=0 even if the goal is later reached.
4. INVERT=1: send 00,10 (up,left → down,right). Expect (0,1) then (1,1).
5. Assert dir_valid=11 together with stream_done. Expect the move applied (y=1), step_count=1, then CHECK, then done.
6. Drop rst mid-walk after 3 moves. Expect immediate IDLE: x/y=(0,0), step_count=0, busy=0. A following dir_valid is ignored until start.
